keypad_scanner: RTL and testbench

- Scans a 4x4 hex matrix keypad (PmodKYPD-style); the input-side counterpart of the board's multiplexed 7-segment display path.
- Drives one column low at a time and samples the active-low rows.
- Debounces single-key presses and reports each accepted key as a one-cycle event with a 4-bit code.
- Shifts accepted digits into a 32-bit entry register that can feed the display's 32-bit number input directly.

---
 rtl/keypad_scanner.sv | 196 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, debounces
// single-key presses over full sweeps and shifts accepted digits into a 32-bit entry register.
module keypad_scanner #(
   parameter int SCAN_CYCLES     = 12500,
   parameter int DEBOUNCE_SWEEPS = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [3:0]  row_n,
   input  logic        clear,
   output logic [3:0]  col_n,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_held,
   output logic [31:0] number
);

   localparam int CNT_W = $clog2(SCAN_CYCLES);
   localparam int DB_W  = $clog2(DEBOUNCE_SWEEPS + 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [DB_W-1:0]  DB_TARGET  = DB_W'(DEBOUNCE_SWEEPS);

   typedef enum logic [1:0] {IDLE, PRESS_CHECK, HELD, RELEASE_CHECK} state_t;
   typedef enum logic [1:0] {CL_NONE, CL_SINGLE, CL_MULTI} sweep_class_t;

   logic [CNT_W-1:0] dwell;
   logic [1:0]       col_idx;
   logic [1:0]       col_next;
   logic [3:0]       row_meta;
   logic [3:0]       row_sync;
   logic [15:0]      snapshot;
   logic [15:0]      full_snap;
   logic             sample_edge;
   logic             sweep_done;
   logic [4:0]       hits;
   logic [3:0]       hit_idx;
   logic [3:0]       hit_code;
   sweep_class_t     sweep_class;
   state_t           state;
   logic [DB_W-1:0]  db_count;
   logic [DB_W-1:0]  count_inc;
   logic [3:0]       candidate;

   function automatic logic [3:0] map_code(input logic [3:0] idx);
      case (idx)
         4'd0:    map_code = 4'h1;
         4'd1:    map_code = 4'h4;
         4'd2:    map_code = 4'h7;
         4'd4:    map_code = 4'h2;
         4'd5:    map_code = 4'h5;
         4'd6:    map_code = 4'h8;
         4'd7:    map_code = 4'hF;
         4'd8:    map_code = 4'h3;
         4'd9:    map_code = 4'h6;
         4'd10:   map_code = 4'h9;
         4'd11:   map_code = 4'hE;
         4'd12:   map_code = 4'hA;
         4'd13:   map_code = 4'hB;
         4'd14:   map_code = 4'hC;
         4'd15:   map_code = 4'hD;
         default: map_code = 4'h0;
      endcase
   endfunction

   assign col_next    = col_idx + 2'd1;
   assign sample_edge = (dwell == DWELL_LAST);
   assign sweep_done  = sample_edge && (col_idx == 2'd3);
   assign count_inc   = (db_count == DB_TARGET) ? db_count : db_count + 1'b1;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dwell   <= '0;
         col_idx <= 2'd0;
         col_n   <= 4'b1110;
      end else if (sample_edge) begin
         dwell   <= '0;
         col_idx <= col_next;
         col_n   <= ~(4'b0001 << col_next);
      end else begin
         dwell   <= dwell + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= row_n;
         row_sync <= row_meta;
      end
   end

   // The column being captured this edge is spliced in, so a completing sweep sees all 16 bits.
   // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
   always_comb begin
      full_snap = snapshot;
      if (sample_edge) full_snap[{col_idx, 2'b00} +: 4] = ~row_sync;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)          snapshot <= '0;
      else if (sample_edge) snapshot <= full_snap;
   end

   always_comb begin
      hits    = '0;
      hit_idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (full_snap[i]) begin
            hits    = hits + 5'd1;
            hit_idx = 4'(i);
         end
      end
      if (hits == 5'd0)      sweep_class = CL_NONE;
      else if (hits == 5'd1) sweep_class = CL_SINGLE;
      else                   sweep_class = CL_MULTI;
      hit_code = map_code(hit_idx);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         db_count  <= '0;
         candidate <= 4'h0;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (sweep_done) begin
            case (state)
               IDLE: begin
                  if (sweep_class == CL_SINGLE) begin
                     candidate <= hit_code;
                     db_count  <= DB_W'(1);
                     if (DEBOUNCE_SWEEPS == 1) begin
                        state     <= HELD;
                        key_code  <= hit_code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                     end else begin
                        state     <= PRESS_CHECK;
                     end
                  end
               end
               PRESS_CHECK: begin
                  if (sweep_class == CL_SINGLE && hit_code == candidate) begin
                     db_count <= count_inc;
                     if (count_inc >= DB_TARGET) begin
                        state     <= HELD;
                        key_code  <= candidate;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                     end
                  end else begin
                     state <= IDLE;
                  end
               end
               HELD: begin
                  if (sweep_class == CL_NONE) begin
                     db_count <= DB_W'(1);
                     if (DEBOUNCE_SWEEPS == 1) begin
                        state    <= IDLE;
                        key_held <= 1'b0;
                     end else begin
                        state    <= RELEASE_CHECK;
                     end
                  end
               end
               RELEASE_CHECK: begin
                  if (sweep_class == CL_NONE) begin
                     db_count <= count_inc;
                     if (count_inc >= DB_TARGET) begin
                        state    <= IDLE;
                        key_held <= 1'b0;
                     end
                  end else begin
                     state <= HELD;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Clear takes priority so a clear landing on a shift still empties the entry.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)        number <= '0;
      else if (clear)     number <= '0;
      else if (key_valid) number <= {number[27:0], key_code};
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model answers the column drive,
// expected key codes are queued at stimulus time and popped on each key_valid pulse.
module tb_keypad_scanner;

   localparam int SCAN  = 8;
   localparam int DB    = 3;
   localparam int SWEEP = 4 * SCAN;

   logic        clk = 1'b0;
   logic        resetn;
   logic        clear;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_held;
   logic [31:0] number;

   logic [15:0] pressed;
   logic [3:0]  exp_q[$];
   int          checks      = 0;
   int          failures    = 0;
   int          pulse_count = 0;
   int          stray       = 0;

   keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_SWEEPS(DB)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .row_n     (row_n),
      .clear     (clear),
      .col_n     (col_n),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_held  (key_held),
      .number    (number)
   );

   always #5 clk = ~clk;

   // Keypad model: a pressed switch pulls its row low while its column is driven low.
   always_comb begin
      row_n = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (pressed[c*4+r] && !col_n[c]) row_n[r] = 1'b0;
   end

   function automatic logic [15:0] key_mask(input logic [3:0] code);
      case (code)
         4'h1: key_mask = 16'h0001;  4'h4: key_mask = 16'h0002;
         4'h7: key_mask = 16'h0004;  4'h0: key_mask = 16'h0008;
         4'h2: key_mask = 16'h0010;  4'h5: key_mask = 16'h0020;
         4'h8: key_mask = 16'h0040;  4'hF: key_mask = 16'h0080;
         4'h3: key_mask = 16'h0100;  4'h6: key_mask = 16'h0200;
         4'h9: key_mask = 16'h0400;  4'hE: key_mask = 16'h0800;
         4'hA: key_mask = 16'h1000;  4'hB: key_mask = 16'h2000;
         4'hC: key_mask = 16'h4000;  default: key_mask = 16'h8000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic sweeps(input logic [15:0] keys, input int n);
      pressed = keys;
      repeat (n * SWEEP) @(negedge clk);
   endtask

   // Leaves the bench on the negedge of the first cycle of a sweep (column 0, dwell 0).
   task automatic align();
      int guard;
      guard = 0;
      while (col_n !== 4'b0111 && guard < 200) begin @(negedge clk); guard++; end
      while (col_n !== 4'b1110 && guard < 200) begin @(negedge clk); guard++; end
      check("align_within_bound", 32'(guard < 200), 32'd1);
   endtask

   task automatic press_release(input logic [3:0] code);
      exp_q.push_back(code);
      sweeps(key_mask(code), DB);
      sweeps(16'h0000, DB);
   endtask

   task automatic check_reset_outputs();
      check("rst_col_n", {28'd0, col_n}, 32'h0000000E);
      check("rst_key_valid", {31'd0, key_valid}, 32'd0);
      check("rst_key_code", {28'd0, key_code}, 32'd0);
      check("rst_key_held", {31'd0, key_held}, 32'd0);
      check("rst_number", number, 32'd0);
   endtask

   // Scoreboard side: sampled 2 time units after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (key_valid) begin
            pulse_count++;
            if (exp_q.size() > 0) begin
               logic [3:0] e;
               e = exp_q.pop_front();
               check("key_code_on_pulse", {28'd0, key_code}, {28'd0, e});
            end else begin
               stray++;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] exp_col;
      resetn  = 1'b0;
      clear   = 1'b0;
      pressed = 16'h0000;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      resetn = 1'b1;

      // Idle scan: column sequence, 8 cycles per column.
      align();
      for (int k = 0; k < 2 * SWEEP; k++) begin
         exp_col = ~(4'b0001 << ((k / SCAN) % 4));
         check("col_sequence", {28'd0, col_n}, {28'd0, exp_col});
         @(negedge clk);
      end
      check("idle_pulses", pulse_count, 0);
      check("idle_number", number, 32'd0);

      // Steady key 8 (column 1, row 2).
      exp_q.push_back(4'h8);
      sweeps(key_mask(4'h8), 2);
      check("k8_no_pulse_after_2", pulse_count, 0);
      sweeps(key_mask(4'h8), 1);
      check("k8_pulse_after_3", pulse_count, 1);
      check("k8_held_set", {31'd0, key_held}, 32'd1);
      check("k8_number_not_yet", number, 32'd0);
      sweeps(key_mask(4'h8), 2);
      check("k8_number", number, 32'h00000008);
      check("k8_single_pulse", pulse_count, 1);
      sweeps(16'h0000, 2);
      check("k8_held_during_release", {31'd0, key_held}, 32'd1);
      sweeps(16'h0000, 1);
      check("k8_held_dropped", {31'd0, key_held}, 32'd0);

      // Bouncing key 5: broken after two sweeps, then three clean ones.
      exp_q.push_back(4'h5);
      sweeps(key_mask(4'h5), 2);
      sweeps(16'h0000, 1);
      sweeps(key_mask(4'h5), 2);
      check("k5_no_early_pulse", pulse_count, 1);
      sweeps(key_mask(4'h5), 1);
      check("k5_pulse", pulse_count, 2);
      check("k5_code", {28'd0, key_code}, 32'h5);
      sweeps(16'h0000, DB);
      check("k5_number", number, 32'h00000085);

      // Two keys together are never accepted.
      sweeps(key_mask(4'h3) | key_mask(4'h9), 10);
      check("multi_no_pulse", pulse_count, 2);
      check("multi_number", number, 32'h00000085);
      check("multi_not_held", {31'd0, key_held}, 32'd0);
      sweeps(16'h0000, 1);

      // Nine digits: the oldest ones fall off the top.
      for (int d = 1; d <= 9; d++) press_release(4'(d));
      check("digits_number", number, 32'h23456789);
      check("digits_pulses", pulse_count, 11);

      // Clear lands on the same edge as the shift for A.
      exp_q.push_back(4'hA);
      sweeps(key_mask(4'hA), DB);
      check("a_pulse_now", {31'd0, key_valid}, 32'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear_wins", number, 32'd0);
      check("a_pulses", pulse_count, 12);
      align();
      sweeps(16'h0000, DB);
      check("clear_holds", number, 32'd0);
      press_release(4'hE);
      check("e_number", number, 32'h0000000E);

      // Reset in the middle of a press debounce.
      sweeps(key_mask(4'h6), 2);
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      resetn = 1'b1;
      exp_q.push_back(4'h6);
      sweeps(key_mask(4'h6), 2);
      check("post_reset_no_early", pulse_count, 13);
      sweeps(key_mask(4'h6), 1);
      check("post_reset_pulse", pulse_count, 14);
      check("post_reset_code", {28'd0, key_code}, 32'h6);
      sweeps(16'h0000, DB);
      check("post_reset_number", number, 32'h00000006);

      check("stray_pulses", stray, 0);
      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
